top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top.sv | 232 +++++++++++++++++++++++
 tb/tb_top.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/top.sv
// Single-cycle RV32I subset core (lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq, jal)
// with instruction ROM and data RAM. Define CYCLE_COUNTER_EN to add the 8-bit cycle_count output.
module top #(
  parameter string       MEMFILE    = "riscvtest.txt",
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] WriteData,
  output logic [31:0] DataAdr,
  output logic        MemWrite
`ifdef CYCLE_COUNTER_EN
  ,
  output logic [7:0]  cycle_count
`endif
);

  localparam int unsigned IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int unsigned DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;
  typedef enum logic [1:0] {ResAlu, ResMem, ResPc4} res_sel_e;
  typedef enum logic [1:0] {ImmI, ImmS, ImmB, ImmJ} imm_sel_e;

  // Storage
  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] rf   [32];

  // Built-in default program image
  localparam int unsigned DefWords = 5;
  localparam logic [31:0] DefProg [DefWords] = '{
    32'h0050_0113,
    32'h0050_0193,
    32'h0031_0233,
    32'h0640_2223,
    32'h0000_006f
  };

  // ROM image and register-file power-on state; reset never clears x1..x31.
  initial begin
    for (int i = 0; i < IMEM_WORDS; i++) imem[i] = 32'h0000_0013;
    if (MEMFILE != "") begin
      for (int i = 0; i < DefWords; i++) begin
        if (i < IMEM_WORDS) imem[i] = DefProg[i];
      end
    end
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
  end

  // Datapath signals
  logic [31:0] pc_q, pc_d, pc_plus4, pc_target;
  logic [31:0] instr, imm_ext;
  logic [31:0] rs1_data, rs2_data, src_b;
  logic [31:0] alu_result, read_data, result;
  logic        alu_zero;
  logic [IAW-1:0] imem_idx;
  logic [DAW-1:0] dmem_idx;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;

  // Control signals
  logic     reg_write, mem_write, alu_src, branch, jump;
  alu_op_e  alu_op;
  res_sel_e res_sel;
  imm_sel_e imm_sel;

  // Fetch
  assign imem_idx = IAW'({2'b00, pc_q[31:2]} % IMEM_WORDS);
  assign instr    = imem[imem_idx];

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // Decode; anything not recognised falls through as a no-op.
  always_comb begin
    reg_write = 1'b0;
    mem_write = 1'b0;
    alu_src   = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    alu_op    = AluAdd;
    res_sel   = ResAlu;
    imm_sel   = ImmI;
    case (opcode)
      OpLoad: begin
        if (funct3 == 3'b010) begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          res_sel   = ResMem;
        end
      end
      OpStore: begin
        if (funct3 == 3'b010) begin
          mem_write = 1'b1;
          alu_src   = 1'b1;
          imm_sel   = ImmS;
        end
      end
      OpReg: begin
        case ({funct7, funct3})
          {7'h00, 3'b000}: begin reg_write = 1'b1; alu_op = AluAdd; end
          {7'h20, 3'b000}: begin reg_write = 1'b1; alu_op = AluSub; end
          {7'h00, 3'b010}: begin reg_write = 1'b1; alu_op = AluSlt; end
          {7'h00, 3'b110}: begin reg_write = 1'b1; alu_op = AluOr;  end
          {7'h00, 3'b111}: begin reg_write = 1'b1; alu_op = AluAnd; end
          default: ;
        endcase
      end
      OpImm: begin
        alu_src = 1'b1;
        case (funct3)
          3'b000:  begin reg_write = 1'b1; alu_op = AluAdd; end
          3'b010:  begin reg_write = 1'b1; alu_op = AluSlt; end
          3'b110:  begin reg_write = 1'b1; alu_op = AluOr;  end
          3'b111:  begin reg_write = 1'b1; alu_op = AluAnd; end
          default: ;
        endcase
      end
      OpBranch: begin
        if (funct3 == 3'b000) begin
          branch  = 1'b1;
          alu_op  = AluSub;
          imm_sel = ImmB;
        end
      end
      OpJal: begin
        jump      = 1'b1;
        reg_write = 1'b1;
        res_sel   = ResPc4;
        imm_sel   = ImmJ;
      end
      default: ;
    endcase
  end

  // Immediate generation
  always_comb begin
    imm_ext = 32'h0;
    case (imm_sel)
      ImmI: imm_ext = {{20{instr[31]}}, instr[31:20]};
      ImmS: imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB: imm_ext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmJ: imm_ext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm_ext = 32'h0;
    endcase
  end

  // Register file reads
  assign rs1_data = (rs1 == 5'd0) ? 32'h0 : rf[rs1];
  assign rs2_data = (rs2 == 5'd0) ? 32'h0 : rf[rs2];
  assign src_b    = alu_src ? imm_ext : rs2_data;

  // ALU
  always_comb begin
    alu_result = 32'h0;
    case (alu_op)
      AluAdd:  alu_result = rs1_data + src_b;
      AluSub:  alu_result = rs1_data - src_b;
      AluAnd:  alu_result = rs1_data & src_b;
      AluOr:   alu_result = rs1_data | src_b;
      AluSlt:  alu_result = {31'h0, $signed(rs1_data) < $signed(src_b)};
      default: alu_result = 32'h0;
    endcase
  end
  assign alu_zero = (alu_result == 32'h0);

  // Data memory; the low address bits are ignored so unaligned accesses never trap.
  assign dmem_idx  = DAW'({2'b00, alu_result[31:2]} % DMEM_WORDS);
  assign read_data = dmem[dmem_idx];

  assign DataAdr   = alu_result;
  assign WriteData = rs2_data;
  // Gating with reset aborts an in-flight store the moment reset asserts.
  assign MemWrite  = mem_write & reset;

  always_ff @(posedge clk) begin
    if (MemWrite) dmem[dmem_idx] <= WriteData;
  end

  // Writeback
  assign pc_plus4  = pc_q + 32'd4;
  assign pc_target = pc_q + imm_ext;

  always_comb begin
    result = alu_result;
    case (res_sel)
      ResAlu:  result = alu_result;
      ResMem:  result = read_data;
      ResPc4:  result = pc_plus4;
      default: result = alu_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset && reg_write && (rd != 5'd0)) rf[rd] <= result;
  end

  // Next PC
  assign pc_d = ((branch && alu_zero) || jump) ? pc_target : pc_plus4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= 32'h0;
    else        pc_q <= pc_d;
  end

`ifdef CYCLE_COUNTER_EN
  logic [7:0] cycle_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycle_q <= 8'h0;
    else        cycle_q <= cycle_q + 8'd1;
  end

  assign cycle_count = cycle_q;
`endif

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for top: directed programs are written into the instruction ROM, expected
// stores are queued, and a negedge monitor pops and checks every store the core issues.
module tb_top;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] WriteData, DataAdr;
  logic        MemWrite;
`ifdef CYCLE_COUNTER_EN
  logic [7:0]  cycle_count;
`endif

  top #(
    .MEMFILE    (""),
    .IMEM_WORDS (64),
    .DMEM_WORDS (64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .WriteData (WriteData),
    .DataAdr   (DataAdr),
    .MemWrite  (MemWrite)
`ifdef CYCLE_COUNTER_EN
    ,
    .cycle_count (cycle_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
  } st_t;

  st_t         exp_q[$];
  logic [31:0] prog[$];
  int          total = 0;
  int          bad = 0;

  // Instruction encoders
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
    logic [11:0] im;
    im = imm[11:0];
    return {im, rs1[4:0], f3, rd[4:0], op};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'h13);
  endfunction

  function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 3'b010, rd, 7'h03);
  endfunction

  function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
    logic [11:0] im;
    im = imm[11:0];
    return {im[11:5], rs2[4:0], rs1[4:0], 3'b010, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] beq(input int rs1, input int rs2, input int imm);
    logic [12:0] im;
    im = imm[12:0];
    return {im[12], im[10:5], rs2[4:0], rs1[4:0], 3'b000, im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] jal(input int rd, input int imm);
    logic [20:0] im;
    im = imm[20:0];
    return {im[20], im[10:1], im[11], im[19:12], rd[4:0], 7'h6f};
  endfunction

  function automatic logic [31:0] halt();
    return jal(0, 0);
  endfunction

  task automatic expect_store(input logic [31:0] adr, input logic [31:0] data);
    st_t e;
    e.adr  = adr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Must be called while reset is low.
  task automatic load_prog();
    for (int i = 0; i < 64; i++) dut.imem[i] = 32'h0000_0013;
    for (int i = 0; i < prog.size(); i++) dut.imem[i] = prog[i];
    prog.delete();
  endtask

  task automatic drain(input string name, input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d stores still pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_prog(input string name, input int budget);
    #1 reset = 1'b0;
    load_prog();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    drain(name, budget);
  endtask

  // Monitor: MemWrite must stay low in reset; each store must match the queue head.
  always @(negedge clk) begin : monitor
    st_t e;
    if (!reset) begin
      total++;
      if (MemWrite !== 1'b0) begin
        bad++;
        $display("FAIL reset_memwrite: got %b want 0", MemWrite);
      end
`ifdef CYCLE_COUNTER_EN
      total++;
      if (cycle_count !== 8'd0) begin
        bad++;
        $display("FAIL reset_cycle_count: got %0d want 0", cycle_count);
      end
`endif
    end else if (MemWrite === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_store: adr=%h data=%h want no store", DataAdr, WriteData);
      end else begin
        e = exp_q.pop_front();
        if (DataAdr !== e.adr || WriteData !== e.data) begin
          bad++;
          $display("FAIL store: adr=%h data=%h want adr=%h data=%h",
                   DataAdr, WriteData, e.adr, e.data);
        end
      end
    end
  end

  initial begin
    @(posedge clk);

    // Signed slt: -1 < 1
    prog = '{addi(1, 0, -1), addi(2, 0, 1), enc_r(7'h00, 2, 1, 3'b010, 3), sw(3, 0, 0), halt()};
    expect_store(32'd0, 32'd1);
    run_prog("slt_signed", 20);

    // Taken beq skips the addi
    prog = '{beq(0, 0, 8), addi(5, 0, 7), sw(5, 0, 4), halt()};
    expect_store(32'd4, 32'd0);
    run_prog("beq_taken", 20);

    // x0 is hardwired
    prog = '{addi(0, 0, 5), sw(0, 0, 8), halt()};
    expect_store(32'd8, 32'd0);
    run_prog("x0_write", 20);

    // R and I ALU ops, negative store offset
    prog = '{addi(6, 0, 12), addi(7, 0, 10),
             enc_r(7'h20, 7, 6, 3'b000, 8), enc_r(7'h00, 7, 6, 3'b111, 9),
             enc_r(7'h00, 7, 6, 3'b110, 10), enc_r(7'h00, 7, 6, 3'b000, 11),
             sw(8, 0, 12), sw(9, 0, 16), sw(10, 0, 20), sw(11, 0, 24),
             enc_i(11, 7, 3'b010, 12, 7'h13), sw(12, 0, 28),
             enc_i(6, 6, 3'b111, 13, 7'h13), enc_i(5, 7, 3'b110, 14, 7'h13),
             sw(13, 0, 32), sw(14, 6, -4), halt()};
    expect_store(32'd12, 32'd2);
    expect_store(32'd16, 32'd8);
    expect_store(32'd20, 32'd14);
    expect_store(32'd24, 32'd22);
    expect_store(32'd28, 32'd1);
    expect_store(32'd32, 32'd4);
    expect_store(32'd8,  32'd15);
    run_prog("alu_ops", 40);

    // Loads, load-use, unaligned and wrapped addresses
    prog = '{addi(15, 0, -100), sw(15, 0, 40), lw(16, 0, 40),
             enc_r(7'h00, 16, 16, 3'b000, 17), sw(17, 0, 44),
             lw(18, 0, 46), sw(18, 0, 48), lw(19, 0, 300), sw(19, 0, 52),
             sw(15, 0, 58), lw(26, 0, 56), sw(26, 0, 60), halt()};
    expect_store(32'd40, 32'hFFFF_FF9C);
    expect_store(32'd44, 32'hFFFF_FF38);
    expect_store(32'd48, 32'hFFFF_FF38);
    expect_store(32'd52, 32'hFFFF_FF38);
    expect_store(32'd58, 32'hFFFF_FF9C);
    expect_store(32'd60, 32'hFFFF_FF9C);
    run_prog("load_store", 40);

    // jal link/target, untaken beq, unsupported opcode (lui) as no-op
    prog = '{jal(20, 12), sw(0, 0, 60), sw(0, 0, 60), sw(20, 0, 56),
             beq(20, 0, 12), {20'hFFFFF, 5'd20, 7'h37}, sw(20, 0, 60), halt()};
    expect_store(32'd56, 32'd4);
    expect_store(32'd60, 32'd4);
    run_prog("jal_beq", 30);

    // Reference-style program: store 10 to address 100 within 24 cycles
    prog = '{addi(2, 0, 5), addi(3, 0, 5), enc_r(7'h00, 3, 2, 3'b000, 4), sw(4, 0, 100), halt()};
    expect_store(32'd100, 32'd10);
    run_prog("store_100", 24);

    // Mid-program reset aborts the store and blocks register writes while held
    prog = '{addi(24, 24, 1), sw(24, 0, 68), halt()};
    #1 reset = 1'b0;
    load_prog();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    expect_store(32'd68, 32'd2);
    #1 reset = 1'b1;
    drain("mid_reset", 20);

`ifdef CYCLE_COUNTER_EN
    prog = '{halt()};
    #1 reset = 1'b0;
    load_prog();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (260) @(posedge clk);
    #1;
    total++;
    if (cycle_count !== 8'd4) begin
      bad++;
      $display("FAIL cycle_wrap: got %0d want 4", cycle_count);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
